// File: rtl/pc_sequencer_pkg.sv
// Shared state encodings and default parameters for the PC sequencer.
// Pure declarations: no logic and no latency of its own.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_DELIVER = 3'd2,
        ST_HALTED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
    localparam int          DEF_MAX_WAIT   = 16;

endpackage

// File: rtl/pc_sequencer_next_addr.sv
// Next-PC arithmetic: word-granular increment or absolute jump target.
// Purely combinational; it has no flow control.
module program_counter_next_addr (
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [15:0] jump_offset,
    output logic [31:0] next_pc
);

    logic [31:0] offset_sext;

    assign offset_sext = {{16{jump_offset[15]}}, jump_offset};
    assign next_pc     = jump ? {offset_sext[29:0], 2'b00} : pc + 32'd1;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: issues imem reads at pc and hands each word to the decoder.
// First imem_req one cycle after start, one idle cycle per instruction; stalls in DELIVER until instr_ready.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEF_RESET_ADDR,
    parameter int          MAX_WAIT   = DEF_MAX_WAIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        jump,
    input  logic [15:0] jump_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic        busy,
    output logic        fault,
    output logic [31:0] fetch_count
);

    localparam int WW = $clog2(MAX_WAIT) + 1;

    state_t        state, state_nxt;
    logic [31:0]   pc_nxt, instr_nxt, count_nxt, next_pc;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          halt_pend, halt_nxt;

    program_counter_next_addr u_next_addr (
        .pc          (pc),
        .jump        (jump),
        .jump_offset (jump_offset),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_ADDR;
            instr       <= 32'd0;
            fetch_count <= 32'd0;
            wait_cnt    <= '0;
            halt_pend   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            fetch_count <= count_nxt;
            wait_cnt    <= wait_nxt;
            halt_pend   <= halt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instr;
        count_nxt = fetch_count;
        wait_nxt  = wait_cnt;
        halt_nxt  = halt_pend;
        case (state)
            ST_IDLE, ST_HALTED: begin
                if (start) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                // A halt here only marks the boundary; the read in flight still completes.
                if (halt_req) halt_nxt = 1'b1;
                if (imem_ack) begin
                    instr_nxt = imem_rdata;
                    wait_nxt  = '0;
                    state_nxt = ST_DELIVER;
                end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                    wait_nxt  = '0;
                    state_nxt = ST_FAULT;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            ST_DELIVER: begin
                if (halt_req) halt_nxt = 1'b1;
                if (instr_ready) begin
                    pc_nxt    = next_pc;
                    count_nxt = fetch_count + 32'd1;
                    if (halt_pend || halt_req) begin
                        halt_nxt  = 1'b0;
                        state_nxt = ST_HALTED;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign imem_req    = (state == ST_REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_DELIVER);
    assign busy        = (state == ST_REQ) || (state == ST_DELIVER);
    assign fault       = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table of single fetches plus
// hand-written halt, stall/reset and fault sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt_req, jump, imem_ack, instr_ready;
    logic [15:0] jump_offset;
    logic [31:0] imem_rdata;
    logic        imem_req, instr_valid, busy, fault;
    logic [31:0] imem_addr, instr, pc, fetch_count;

    int total  = 0;
    int passed = 0;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
        logic        jmp;
        logic [15:0] off;
        logic [31:0] addr;
        logic [31:0] nxt;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .jump        (jump),
        .jump_offset (jump_offset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One full fetch starting from a negedge in REQ; ends on the negedge after the handshake.
    task automatic run_vec(input vec_t v);
        chk("req_asserted", 32'(imem_req), 32'd1);
        chk("req_addr", imem_addr, v.addr);
        for (int i = 0; i < v.delay; i++) begin
            @(negedge clk);
            chk("req_held", 32'(imem_req), 32'd1);
            chk("addr_held", imem_addr, v.addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("deliver_valid", 32'(instr_valid), 32'd1);
        chk("deliver_no_req", 32'(imem_req), 32'd0);
        chk("deliver_instr", instr, v.rdata);
        instr_ready = 1'b1;
        jump        = v.jmp;
        jump_offset = v.off;
        @(negedge clk);
        instr_ready = 1'b0;
        jump        = 1'b0;
        jump_offset = 16'h0;
        chk("next_pc", pc, v.nxt);
        chk("fetch_count", fetch_count, v.cnt);
    endtask

    initial begin
        vecs[0]  = '{1, 32'hA000_0000, 1'b0, 16'h0000, 32'h0000_0000, 32'h0000_0001, 32'd1};
        vecs[1]  = '{1, 32'hA000_0001, 1'b0, 16'h0000, 32'h0000_0001, 32'h0000_0002, 32'd2};
        vecs[2]  = '{1, 32'hA000_0002, 1'b0, 16'h0000, 32'h0000_0002, 32'h0000_0003, 32'd3};
        vecs[3]  = '{0, 32'hA000_0003, 1'b0, 16'h1234, 32'h0000_0003, 32'h0000_0004, 32'd4};
        vecs[4]  = '{0, 32'hA000_0004, 1'b0, 16'h0000, 32'h0000_0004, 32'h0000_0005, 32'd5};
        vecs[5]  = '{0, 32'hA000_0005, 1'b1, 16'h0004, 32'h0000_0005, 32'h0000_0010, 32'd6};
        vecs[6]  = '{2, 32'hA000_0010, 1'b1, 16'hFFFF, 32'h0000_0010, 32'hFFFF_FFFC, 32'd7};
        vecs[7]  = '{0, 32'hB000_0000, 1'b0, 16'h0000, 32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'd8};
        vecs[8]  = '{0, 32'hB000_0001, 1'b0, 16'h0000, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd9};
        vecs[9]  = '{0, 32'hB000_0002, 1'b0, 16'h0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd10};
        vecs[10] = '{1, 32'hB000_0003, 1'b0, 16'h0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'd11};
        vecs[11] = '{0, 32'hC000_0000, 1'b1, 16'h8000, 32'h0000_0000, 32'hFFFE_0000, 32'd12};
        vecs[12] = '{3, 32'hC000_0001, 1'b0, 16'h0000, 32'hFFFE_0000, 32'hFFFE_0001, 32'd13};

        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; jump = 1'b0; jump_offset = 16'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;

        #12;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_count", fetch_count, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 32'(imem_req), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Halt during REQ: outstanding read completes, then stop.
        halt_req = 1'b1;
        @(negedge clk);
        halt_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("halt_req_held", 32'(imem_req), 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("halt_word_delivered", instr, 32'h1111_2222);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("halted_busy", 32'(busy), 32'd0);
        chk("halted_pc", pc, 32'hFFFE_0002);
        chk("halted_count", fetch_count, 32'd14);
        @(negedge clk);
        chk("halted_no_req", 32'(imem_req), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("resume_req", 32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'hFFFE_0002);

        // Pending halt was cleared: this fetch continues to REQ.
        imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
        @(negedge clk);
        imem_ack = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        chk("no_stale_halt", 32'(imem_req), 32'd1);

        // Halt raised in the handshake cycle itself.
        imem_ack = 1'b1; imem_rdata = 32'h5555_6666;
        @(negedge clk);
        imem_ack = 1'b0; instr_ready = 1'b1; halt_req = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0; halt_req = 1'b0;
        chk("same_cycle_halt_busy", 32'(busy), 32'd0);
        chk("same_cycle_halt_pc", pc, 32'hFFFE_0004);

        // Decoder stall, then reset in DELIVER.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h5A5A_A5A5;
        @(negedge clk);
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, 32'h5A5A_A5A5);
            chk("stall_no_req", 32'(imem_req), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_count", fetch_count, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // No ack: fault after MAX_WAIT cycles in REQ.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_no_fault", 32'(fault), 32'd0);
            @(negedge clk);
        end
        chk("fault_set", 32'(fault), 32'd1);
        chk("fault_no_req", 32'(imem_req), 32'd0);
        chk("fault_pc", pc, 32'h0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_start_ignored", 32'(imem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("fault_cleared", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("post_fault_req", 32'(imem_req), 32'd1);
        chk("post_fault_addr", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, SHALL be the PC value loaded at reset.
REQ-002 Parameter MAX_WAIT, default 16, SHALL be the max cycles in REQ without imem_ack before fault.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 start  in  1  SHALL begin or resume fetching from IDLE/HALTED.
REQ-006 halt_req  in  1  SHALL request a stop at the next instruction boundary.
REQ-007 jump  in  1  SHALL select the jump target for the delivered instruction; sampled only on the instr handshake.
REQ-008 jump_offset  in  16  SHALL be the signed jump offset; sampled with jump.
REQ-009 imem_req  out  1  SHALL request an instruction-memory read.
REQ-010 imem_addr  out  32  SHALL be the read address; equals pc.
REQ-011 imem_ack  in  1  SHALL mark imem_rdata valid for one cycle.
REQ-012 imem_rdata  in  32  SHALL be the fetched instruction word.
REQ-013 instr_valid  out  1  SHALL flag instr valid to the decoder.
REQ-014 instr  out  32  SHALL be the registered instruction word.
REQ-015 instr_ready  in  1  SHALL be the decoder accept; handshake = instr_valid && instr_ready.
REQ-016 pc  out  32  SHALL be the current program counter.
REQ-017 busy  out  1  SHALL be high in REQ or DELIVER.
REQ-018 fault  out  1  SHALL be high in FAULT.
REQ-019 fetch_count  out  32  SHALL count completed handshakes, wrapping modulo 2^32.

Function
REQ-020 FSM states SHALL be IDLE, REQ, DELIVER, HALTED, FAULT.
REQ-021 IDLE/HALTED: start=1 -> REQ next cycle; otherwise hold; halt_req ignored.
REQ-022 REQ: imem_req=1, imem_addr=pc, both stable until imem_ack; wait counter increments per cycle without ack.
REQ-023 REQ with imem_ack=1: instr<=imem_rdata, wait counter<=0, -> DELIVER.
REQ-024 REQ with wait counter == MAX_WAIT-1 and imem_ack=0: -> FAULT; imem_req drops next cycle.
REQ-025 DELIVER: instr_valid=1, instr stable until handshake; no imem request issued.
REQ-026 On handshake: pc <= jump ? {sext(jump_offset)[29:0],2'b00} : pc+1; fetch_count+1.
REQ-027 Sequential increment SHALL be +1 (word-granular) and wrap 32'hFFFF_FFFF -> 32'h0000_0000.
REQ-028 Jump target SHALL be absolute: sign-extended offset shifted left 2; e.g. 16'h8000 -> 32'hFFFE_0000.
REQ-029 Pending-halt flag SHALL set on halt_req in any of REQ/DELIVER and clear on entering HALTED.
REQ-030 On handshake with halt pending (incl. halt_req that same cycle): pc update per REQ-026, -> HALTED; else -> REQ.
REQ-031 halt_req during REQ SHALL NOT abort the outstanding read; the fetched word is still delivered.
REQ-032 FAULT SHALL be exited only by reset; pc frozen at the faulting address.
REQ-033 Latency: first imem_req one cycle after start; one-cycle idle imem_req gap per instruction (DELIVER).

Reset
REQ-034 rst_n low SHALL immediately force IDLE, pc=RESET_ADDR, instr=0, fetch_count=0, wait counter=0, halt pending=0.
REQ-035 During reset all outputs SHALL be 0 except pc/imem_addr=RESET_ADDR; reset mid-REQ drops imem_req without waiting for ack.

Structure
REQ-036 Shared package/header SHALL hold state encodings (3-bit) and RESET_ADDR/MAX_WAIT defaults.
REQ-037 Next-PC arithmetic SHALL be one sub-module, program_counter_next_addr (pc, jump, jump_offset -> next pc); FSM, counters, registers in pc_sequencer.

Verification
REQ-038 Reset, start, ack after 1 cycle each, instr_ready=1, jump=0 -> imem_addr 0,1,2,3; fetch_count=3 after third handshake.
REQ-039 Handshake at pc=5 with jump=1, jump_offset=16'h0004 -> next imem_addr=32'h0000_0010.
REQ-040 pc=32'hFFFF_FFFF, handshake jump=0 -> pc=0; jump_offset=16'hFFFF -> pc=32'hFFFF_FFFC.
REQ-041 halt_req in REQ, ack 3 cycles later -> word delivered, pc advances once, HALTED, busy=0; start -> resume at new pc.
REQ-042 No ack for MAX_WAIT=16 cycles -> fault=1, imem_req=0, pc unchanged; start ignored until rst_n pulse.
REQ-043 instr_ready held 0 for 5 cycles in DELIVER -> instr stable, imem_req=0; rst_n mid-DELIVER -> IDLE, pc=RESET_ADDR.
